// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and defaults for the MIPS pipeline stages.
package pipeline_pkg;
   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 32'h0000_0000;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} fetch_state_t;
   typedef struct packed {
      logic [INSTR_W-1:0] pc_next;
      logic [INSTR_W-1:0] instruction;
      logic               valid;
   } if_id_t;
   function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] a);
      return {a[INSTR_W-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: generic stage register with load/bubble/hold; bubble beats load.
module if_id_reg #(
   parameter int W = 65,
   parameter logic [W-1:0] BUBBLE = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         bubble,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or posedge reset)
      if (reset) q <= BUBBLE;
      else if (bubble) q <= BUBBLE;
      else if (load) q <= d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, imem req/ack handshake and IF/ID load with stall/redirect handling.
module fetch_stage import pipeline_pkg::*; #(
   parameter logic [INSTR_W-1:0] RESET_PC = DEF_RESET_PC,
   parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pc_stall,
   input  logic               IF_ID_stall,
   input  logic               pc_src,
   input  logic [INSTR_W-1:0] pc_decode,
   output logic               imem_req,
   output logic [INSTR_W-1:0] imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] if_id_pc_next,
   output logic [INSTR_W-1:0] if_id_instruction,
   output logic               if_id_valid,
   output logic               fetch_busy
);
   fetch_state_t state, state_nx;
   logic [INSTR_W-1:0] pc, pc_nx, pc_plus4, target, hold_buf, drop_addr;
   logic stall, redirect, ld, bub, buf_we, drop_we;
   if_id_t d, q;

   assign stall = pc_stall | IF_ID_stall;
   assign redirect = pc_src & ~IF_ID_stall;
   assign pc_plus4 = pc + 32'd4;
   assign target = word_align(pc_decode);

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= S_IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: state_nx = S_REQ;
         S_REQ:  state_nx = redirect ? (imem_ack ? S_REQ : S_DROP) : (imem_ack && stall) ? S_HOLD : S_REQ;
         S_HOLD: state_nx = (redirect || !stall) ? S_REQ : S_HOLD;
         S_DROP: state_nx = imem_ack ? S_REQ : S_DROP;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req = (state == S_REQ) || (state == S_DROP);
      imem_addr = (state == S_DROP) ? drop_addr : pc;
      fetch_busy = state != S_REQ;
   end

   // Datapath controls: a redirect always wins; pc_stall only blocks the sequential increment.
   always_comb begin
      pc_nx = pc;
      ld = 1'b0;
      bub = 1'b0;
      buf_we = 1'b0;
      drop_we = 1'b0;
      d = '{pc_next: pc_plus4, instruction: (state == S_HOLD) ? hold_buf : imem_rdata, valid: 1'b1};
      case (state)
         S_REQ:
            if (redirect) begin
               pc_nx = target;
               bub = 1'b1;
               drop_we = !imem_ack;
            end else if (imem_ack && !stall) begin
               pc_nx = pc_plus4;
               ld = 1'b1;
            end else if (imem_ack) buf_we = 1'b1;
            else bub = !stall;
         S_HOLD:
            if (redirect) begin
               pc_nx = target;
               bub = 1'b1;
            end else if (!stall) begin
               pc_nx = pc_plus4;
               ld = 1'b1;
            end
         S_DROP: begin
            pc_nx = redirect ? target : pc;
            bub = !IF_ID_stall;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pc <= RESET_PC;
         hold_buf <= '0;
         drop_addr <= '0;
      end else begin
         pc <= pc_nx;
         if (buf_we) hold_buf <= imem_rdata;
         if (drop_we) drop_addr <= pc;
      end

   if_id_reg #(.W($bits(if_id_t)), .BUBBLE({32'h0, NOP_INSTR, 1'b0})) u_if_id (
      .clk(clk),
      .reset(reset),
      .load(ld),
      .bubble(bub),
      .d(d),
      .q(q)
   );

   assign if_id_pc_next = q.pc_next;
   assign if_id_instruction = q.instruction;
   assign if_id_valid = q.valid;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a controllable-ack memory model.
module tb_fetch_stage;
   logic clk = 1'b0, reset = 1'b1;
   logic pc_stall = 1'b0, IF_ID_stall = 1'b0, pc_src = 1'b0, ack_en = 1'b0;
   logic [31:0] pc_decode = '0;
   logic imem_req, imem_ack, if_id_valid, fetch_busy;
   logic [31:0] imem_addr, imem_rdata, if_id_pc_next, if_id_instruction;
   logic [64:0] sb[$];
   int total = 0, bad = 0;

   fetch_stage dut (
      .clk(clk), .reset(reset), .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall),
      .pc_src(pc_src), .pc_decode(pc_decode), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_id_pc_next(if_id_pc_next),
      .if_id_instruction(if_id_instruction), .if_id_valid(if_id_valid), .fetch_busy(fetch_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mw(input logic [31:0] a);
      return a ^ 32'h8C00_1234;
   endfunction

   assign imem_ack = imem_req & ack_en;
   assign imem_rdata = imem_ack ? mw(imem_addr) : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void push(input logic [31:0] pn, input logic [31:0] ins, input logic v);
      sb.push_back({pn, ins, v});
   endfunction

   task automatic tick(input string tag);
      logic [64:0] e;
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      chk(tag, {if_id_pc_next, if_id_instruction, if_id_valid}, e);
   endtask

   task automatic req_at(input string tag, input logic [31:0] a);
      #1;
      chk({tag, "_req"}, imem_req, 1'b1);
      chk({tag, "_addr"}, imem_addr, a);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      #1;
      chk("rst_req", imem_req, 1'b0);
      chk("rst_busy", fetch_busy, 1'b1);
      chk("rst_ifid", {if_id_pc_next, if_id_instruction, if_id_valid}, 65'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("idle_req", imem_req, 1'b0);
      push(0, 0, 0);
      tick("idle_ifid");
      ack_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req_at("zw", 32'(4 * i));
         push(32'(4 * i + 4), mw(32'(4 * i)), 1);
         tick("zw_ifid");
      end
      ack_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_at("wait8", 32'h8);
         push(0, 0, 0);
         tick("wait8_bub");
      end
      ack_en = 1'b1;
      req_at("wait8", 32'h8);
      push(12, mw(8), 1);
      tick("wait8_load");
      req_at("zw12", 32'hC);
      push(16, mw(12), 1);
      tick("zw12_ifid");
      pc_stall = 1'b1;
      IF_ID_stall = 1'b1;
      req_at("stall16", 32'h10);
      push(16, mw(12), 1);
      tick("stall16_hold");
      chk("hold_req", imem_req, 1'b0);
      chk("hold_busy", fetch_busy, 1'b1);
      push(16, mw(12), 1);
      tick("hold_ifid");
      pc_stall = 1'b0;
      IF_ID_stall = 1'b0;
      #1;
      chk("hold_rel_req", imem_req, 1'b0);
      push(20, mw(16), 1);
      tick("hold_rel_load");
      for (int i = 0; i < 4; i++) begin
         req_at("zw20", 32'(20 + 4 * i));
         push(32'(24 + 4 * i), mw(32'(20 + 4 * i)), 1);
         tick("zw20_ifid");
      end
      ack_en = 1'b0;
      req_at("w24", 32'h24);
      push(0, 0, 0);
      tick("w24_bub");
      pc_src = 1'b1;
      pc_decode = 32'h43;
      req_at("redir24", 32'h24);
      push(0, 0, 0);
      tick("redir24_bub");
      pc_src = 1'b0;
      req_at("drop", 32'h24);
      chk("drop_busy", fetch_busy, 1'b1);
      push(0, 0, 0);
      tick("drop_bub");
      ack_en = 1'b1;
      req_at("drop_ack", 32'h24);
      push(0, 0, 0);
      tick("drop_ack_bub");
      req_at("tgt40", 32'h40);
      push(32'h44, mw(32'h40), 1);
      tick("tgt40_load");
      IF_ID_stall = 1'b1;
      pc_src = 1'b1;
      pc_decode = 32'h80;
      req_at("nored", 32'h44);
      push(32'h44, mw(32'h40), 1);
      tick("nored_hold");
      IF_ID_stall = 1'b0;
      push(0, 0, 0);
      tick("red_hold_bub");
      pc_src = 1'b0;
      req_at("tgt80", 32'h80);
      push(32'h84, mw(32'h80), 1);
      tick("tgt80_load");
      pc_stall = 1'b1;
      pc_src = 1'b1;
      pc_decode = 32'hFFFF_FFFC;
      req_at("simul", 32'h84);
      push(0, 0, 0);
      tick("simul_bub");
      pc_stall = 1'b0;
      pc_src = 1'b0;
      chk("simul_busy", fetch_busy, 1'b0);
      req_at("wrap", 32'hFFFF_FFFC);
      push(0, mw(32'hFFFF_FFFC), 1);
      tick("wrap_load");
      req_at("wrap0", 32'h0);
      pc_src = 1'b1;
      pc_decode = 32'h100;
      push(0, 0, 0);
      tick("r100_bub");
      pc_src = 1'b0;
      ack_en = 1'b0;
      req_at("w100", 32'h100);
      push(0, 0, 0);
      tick("w100_bub");
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_req", imem_req, 1'b0);
      chk("mid_rst_ifid", {if_id_pc_next, if_id_instruction, if_id_valid}, 65'h0);
      @(negedge clk);
      reset = 1'b0;
      ack_en = 1'b1;
      #1;
      chk("post_rst_idle_req", imem_req, 1'b0);
      push(0, 0, 0);
      tick("post_rst_idle");
      req_at("post_rst", 32'h0);
      push(4, mw(0), 1);
      tick("post_rst_load");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
